// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and elaboration helpers for the matrix-multiply
//               input loader: loader phase encoding, max() used to size the
//               stream element, and a minimum-one-bit clog2 for counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

   // Loader phase: filling A, filling B, or holding a complete operand set.
   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      FULL   = 2'd2
   } ld_state_t;

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Index width that never collapses to zero bits for a single-entry dimension.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_in_loader_idx_counter.sv
`default_nettype none
// ============================================================================
// Module      : idx_counter
// Description : Two-dimensional row/col index counter. The column advances on
//               each increment and wraps at COLS, stepping the row; the row
//               wraps at ROWS so the counter returns to (0,0) after the final
//               element. Clear has priority over increment.
// Ports       : clk, rst    - clock, asynchronous active-high reset
//               i_inc       - advance one element
//               i_clr       - return to (0,0)
//               o_row/o_col - current element index
//               o_wrap      - column is at its last value (next inc wraps it)
//               o_last      - row is at its last value
// Revision    : 1.0 - initial release
// ============================================================================
module idx_counter
   import matmul_pkg::*;
#(
   parameter int ROWS = 2,
   parameter int COLS = 2,
   localparam int ROW_W = clog2_min1(ROWS),
   localparam int COL_W = clog2_min1(COLS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_wrap,
   output logic             o_last
);

   localparam logic [ROW_W-1:0] c_row_max = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] c_col_max = COL_W'(COLS - 1);

   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;
   logic             w_wrap;
   logic             w_last_row;

   assign w_wrap     = (r_col == c_col_max);
   assign w_last_row = (r_row == c_row_max);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_inc) begin
         if (w_wrap) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_wrap = w_wrap;
   assign o_last = w_last_row;

endmodule
`default_nettype wire

// File: rtl/matmul_in_loader.sv
`default_nettype none
// ============================================================================
// Module      : matmul_in_loader
// Description : Deserialises a row-major stream of signed elements (all of A,
//               then all of B) into packed operand arrays for the matrix
//               multiplier, presents them with a valid/ready handshake and
//               checks frame alignment using s_last.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               s_data/s_valid    - stream element and its valid
//               s_last            - marks the final B element of a frame
//               s_ready           - a beat is accepted this cycle if valid
//               A [R1][C1][W_A]   - packed operand A (held while mat_valid)
//               B [R2][C2][W_B]   - packed operand B (held while mat_valid)
//               mat_valid/ready   - operand-set handshake
//               err               - one-cycle pulse, frame discarded
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_in_loader
   import matmul_pkg::*;
#(
   parameter int R1  = 8,
   parameter int C1  = 6,
   parameter int R2  = 6,
   parameter int C2  = 8,
   parameter int W_A = 8,
   parameter int W_B = 8,
   localparam int W_IN = max(W_A, W_B)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [W_IN-1:0]                s_data,
   input  logic                           s_valid,
   input  logic                           s_last,
   output logic                           s_ready,
   output logic [R1-1:0][C1-1:0][W_A-1:0] A,
   output logic [R2-1:0][C2-1:0][W_B-1:0] B,
   output logic                           mat_valid,
   input  logic                           mat_ready,
   output logic                           err
);

   localparam int A_RW = clog2_min1(R1);
   localparam int A_CW = clog2_min1(C1);
   localparam int B_RW = clog2_min1(R2);
   localparam int B_CW = clog2_min1(C2);

   if (C1 != R2) begin : g_dim_check
      $error("matmul_in_loader: C1 (%0d) must equal R2 (%0d)", C1, R2);
   end

   ld_state_t                      r_state;
   logic                           r_mat_valid;
   logic                           r_err;
   logic [R1-1:0][C1-1:0][W_A-1:0] r_a;
   logic [R2-1:0][C2-1:0][W_B-1:0] r_b;

   logic            w_ready;
   logic            w_beat;
   logic            w_in_a;
   logic            w_in_b;
   logic            w_a_end;
   logic            w_b_end;
   logic            w_frame_err;
   logic [A_RW-1:0] w_a_row;
   logic [A_CW-1:0] w_a_col;
   logic [B_RW-1:0] w_b_row;
   logic [B_CW-1:0] w_b_col;
   logic            w_a_wrap;
   logic            w_a_last;
   logic            w_b_wrap;
   logic            w_b_last;

   // Ready is a pure function of phase, gated low for the whole reset pulse.
   assign w_ready = (r_state != FULL) && !rst;
   assign w_beat  = s_valid && w_ready;
   assign w_in_a  = (r_state == LOAD_A);
   assign w_in_b  = (r_state == LOAD_B);
   assign w_a_end = w_a_wrap && w_a_last;
   assign w_b_end = w_b_wrap && w_b_last;

   // s_last is only legal on the final B beat and mandatory there.
   assign w_frame_err = w_beat && ((w_in_a && s_last) ||
                                   (w_in_b && (s_last != w_b_end)));

   // Each counter returns to (0,0) by itself after its final element, so the
   // only explicit clear needed is on a framing error.
   idx_counter #(.ROWS(R1), .COLS(C1)) u_cnt_a (
      .clk    (clk),
      .rst    (rst),
      .i_inc  (w_beat && w_in_a && !w_frame_err),
      .i_clr  (w_frame_err),
      .o_row  (w_a_row),
      .o_col  (w_a_col),
      .o_wrap (w_a_wrap),
      .o_last (w_a_last)
   );

   idx_counter #(.ROWS(R2), .COLS(C2)) u_cnt_b (
      .clk    (clk),
      .rst    (rst),
      .i_inc  (w_beat && w_in_b && !w_frame_err),
      .i_clr  (w_frame_err),
      .o_row  (w_b_row),
      .o_col  (w_b_col),
      .o_wrap (w_b_wrap),
      .o_last (w_b_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= LOAD_A;
         r_mat_valid <= 1'b0;
         r_err       <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
      end else begin
         r_err <= w_frame_err;
         case (r_state)
            LOAD_A: begin
               if (w_beat) begin
                  r_a[w_a_row][w_a_col] <= s_data[W_A-1:0];
                  if (!w_frame_err && w_a_end) begin
                     r_state <= LOAD_B;
                  end
               end
            end
            LOAD_B: begin
               if (w_beat) begin
                  r_b[w_b_row][w_b_col] <= s_data[W_B-1:0];
                  if (w_frame_err) begin
                     r_state <= LOAD_A;
                  end else if (w_b_end) begin
                     r_state     <= FULL;
                     r_mat_valid <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (mat_ready) begin
                  r_state     <= LOAD_A;
                  r_mat_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= LOAD_A;
               r_mat_valid <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready   = w_ready;
   assign A         = r_a;
   assign B         = r_b;
   assign mat_valid = r_mat_valid;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matmul_in_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_in_loader
// Description : Self-checking bench for matmul_in_loader. A 2x2x2x2 instance
//               covers directed framing/handshake/reset scenarios; a
//               default-parameter instance takes randomized throttled frames
//               checked against an index-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_in_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // Small 2x2 instance
   logic [7:0]            sd_s;
   logic                  sv_s, sl_s, sr_s, mv_s, mr_s, err_s;
   logic [1:0][1:0][7:0]  a_s, b_s;

   // Default-parameter instance
   logic [7:0]            sd_b;
   logic                  sv_b, sl_b, sr_b, mv_b, mr_b, err_b;
   logic [7:0][5:0][7:0]  a_b;
   logic [5:0][7:0][7:0]  b_b;

   matmul_in_loader #(.R1(2), .C1(2), .R2(2), .C2(2), .W_A(8), .W_B(8)) dut_s (
      .clk(clk), .rst(rst), .s_data(sd_s), .s_valid(sv_s), .s_last(sl_s), .s_ready(sr_s),
      .A(a_s), .B(b_s), .mat_valid(mv_s), .mat_ready(mr_s), .err(err_s)
   );

   matmul_in_loader dut_b (
      .clk(clk), .rst(rst), .s_data(sd_b), .s_valid(sv_b), .s_last(sl_b), .s_ready(sr_b),
      .A(a_b), .B(b_b), .mat_valid(mv_b), .mat_ready(mr_b), .err(err_b)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] fr_s [8];
   logic [7:0] frb [96];

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Stimulus helper: present one beat on the small instance until accepted.
   task automatic drive_beat_s(input logic [7:0] d, input logic l);
      int t;
      @(negedge clk);
      sd_s = d; sl_s = l; sv_s = 1'b1;
      t = 0;
      while (sr_s !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         vectors++; miscompares++;
         $display("FAIL beat_timeout s_ready=%b required=1", sr_s);
      end
      @(posedge clk); #1;
      sv_s = 1'b0; sl_s = 1'b0;
   endtask

   task automatic consume_s();
      @(negedge clk); mr_s = 1'b1;
      @(posedge clk); #1; mr_s = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sd_s = '0; sv_s = 0; sl_s = 0; mr_s = 0;
      sd_b = '0; sv_b = 0; sl_b = 0; mr_b = 0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (sr_s !== 1'b0 || mv_s !== 1'b0 || err_s !== 1'b0 || a_s !== '0 || b_s !== '0) begin
         miscompares++;
         $display("FAIL reset_small ready=%b valid=%b err=%b A=%h B=%h required 0", sr_s, mv_s, err_s, a_s, b_s);
      end
      vectors++;
      if (sr_b !== 1'b0 || mv_b !== 1'b0 || err_b !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_big ready=%b valid=%b err=%b required 0", sr_b, mv_b, err_b);
      end
      @(negedge clk); rst = 1'b0;
      #1;
      vectors++;
      if (sr_s !== 1'b1 || sr_b !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_reset small=%b big=%b required 1", sr_s, sr_b);
      end
   endtask

   task automatic test_basic_load();
      logic bad;
      for (int i = 0; i < 8; i++) fr_s[i] = 8'(i + 1);
      for (int i = 0; i < 8; i++) begin
         drive_beat_s(fr_s[i], i == 7);
         if (i == 6) begin
            vectors++;
            if (mv_s !== 1'b0) begin
               miscompares++;
               $display("FAIL early_valid mat_valid=%b required=0", mv_s);
            end
         end
      end
      bad = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            if (a_s[r][c] !== fr_s[r*2+c] || b_s[r][c] !== fr_s[4+r*2+c]) bad = 1;
      vectors++;
      if (mv_s !== 1'b1 || err_s !== 1'b0 || bad) begin
         miscompares++;
         $display("FAIL basic_load valid=%b err=%b A=%h B=%h required valid=1 A=04030201 B=08070605", mv_s, err_s, a_s, b_s);
      end
   endtask

   task automatic test_hold();
      logic bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         sv_s = 1'b1; sd_s = 8'($urandom); sl_s = 1'($urandom); mr_s = 1'b0;
         @(posedge clk); #1;
         vectors++;
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
               if (a_s[r][c] !== fr_s[r*2+c] || b_s[r][c] !== fr_s[4+r*2+c]) bad = 1;
         if (sr_s !== 1'b0 || mv_s !== 1'b1 || err_s !== 1'b0 || bad) begin
            miscompares++;
            $display("FAIL hold_cycle%0d ready=%b valid=%b err=%b A=%h B=%h required ready=0 valid=1 data held", i, sr_s, mv_s, err_s, a_s, b_s);
         end
      end
      @(negedge clk); sv_s = 1'b0; sl_s = 1'b0; mr_s = 1'b1;
      @(posedge clk); #1; mr_s = 1'b0;
      vectors++;
      if (mv_s !== 1'b0 || sr_s !== 1'b1) begin
         miscompares++;
         $display("FAIL handshake valid=%b ready=%b required valid=0 ready=1", mv_s, sr_s);
      end
   endtask

   task automatic test_early_last();
      logic bad;
      for (int i = 0; i < 5; i++) drive_beat_s(8'(i + 1), i == 4);
      vectors++;
      if (err_s !== 1'b1 || mv_s !== 1'b0) begin
         miscompares++;
         $display("FAIL early_last_err err=%b valid=%b required err=1 valid=0", err_s, mv_s);
      end
      @(posedge clk); #1;
      vectors++;
      if (err_s !== 1'b0) begin
         miscompares++;
         $display("FAIL err_pulse_width err=%b required=0", err_s);
      end
      for (int i = 0; i < 8; i++) fr_s[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) drive_beat_s(fr_s[i], i == 7);
      bad = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            if (a_s[r][c] !== fr_s[r*2+c] || b_s[r][c] !== fr_s[4+r*2+c]) bad = 1;
      vectors++;
      if (mv_s !== 1'b1 || bad) begin
         miscompares++;
         $display("FAIL reload_after_err valid=%b A=%h B=%h required A=%h%h%h%h B=%h%h%h%h", mv_s, a_s, b_s,
                  fr_s[3], fr_s[2], fr_s[1], fr_s[0], fr_s[7], fr_s[6], fr_s[5], fr_s[4]);
      end
      consume_s();
   endtask

   task automatic test_missing_last();
      for (int i = 0; i < 8; i++) drive_beat_s(8'($urandom), 1'b0);
      vectors++;
      if (err_s !== 1'b1 || mv_s !== 1'b0) begin
         miscompares++;
         $display("FAIL missing_last err=%b valid=%b required err=1 valid=0", err_s, mv_s);
      end
      @(posedge clk); #1;
      vectors++;
      if (mv_s !== 1'b0 || sr_s !== 1'b1 || err_s !== 1'b0) begin
         miscompares++;
         $display("FAIL after_missing_last valid=%b ready=%b err=%b required 0/1/0", mv_s, sr_s, err_s);
      end
   endtask

   task automatic test_negative();
      int exp_a [4];
      logic bad;
      exp_a = '{-128, -1, 127, 0};
      for (int i = 0; i < 4; i++) fr_s[i] = 8'(exp_a[i]);
      for (int i = 4; i < 8; i++) fr_s[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) drive_beat_s(fr_s[i], i == 7);
      bad = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            if ($signed(a_s[r][c]) != exp_a[r*2+c]) bad = 1;
      vectors++;
      if (mv_s !== 1'b1 || bad) begin
         miscompares++;
         $display("FAIL signed_a valid=%b A=%0d,%0d,%0d,%0d required -128,-1,127,0", mv_s,
                  $signed(a_s[0][0]), $signed(a_s[0][1]), $signed(a_s[1][0]), $signed(a_s[1][1]));
      end
      consume_s();
   endtask

   task automatic test_reset_mid();
      logic bad;
      drive_beat_s(8'h11, 1'b0);
      drive_beat_s(8'h22, 1'b0);
      @(negedge clk);
      sv_s = 1'b1; sd_s = 8'h33; rst = 1'b1;
      #1;
      vectors++;
      if (sr_s !== 1'b0 || mv_s !== 1'b0 || err_s !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_async ready=%b valid=%b err=%b required 0", sr_s, mv_s, err_s);
      end
      @(posedge clk); #1;
      vectors++;
      if (sr_s !== 1'b0 || mv_s !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_held ready=%b valid=%b required 0", sr_s, mv_s);
      end
      @(negedge clk); rst = 1'b0; sv_s = 1'b0;
      for (int i = 0; i < 8; i++) fr_s[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) drive_beat_s(fr_s[i], i == 7);
      bad = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            if (a_s[r][c] !== fr_s[r*2+c] || b_s[r][c] !== fr_s[4+r*2+c]) bad = 1;
      vectors++;
      if (mv_s !== 1'b1 || bad) begin
         miscompares++;
         $display("FAIL frame_after_reset valid=%b A=%h B=%h", mv_s, a_s, b_s);
      end
      consume_s();
   endtask

   task automatic test_random_big();
      int idx, cyc, hold;
      logic acc, valid_seen, bad_a, bad_b;
      int br, bc;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 96; k++) frb[k] = 8'($urandom);
         idx = 0; cyc = 0; valid_seen = 0;
         while (idx < 96 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (mv_b !== 1'b0) valid_seen = 1;
            sv_b = ($urandom_range(0, 3) != 0);
            sd_b = frb[idx];
            sl_b = (idx == 95);
            mr_b = 1'($urandom);
            acc = sv_b && sr_b;
            @(posedge clk);
            if (acc) idx++;
         end
         #1;
         sv_b = 1'b0; sl_b = 1'b0; mr_b = 1'b0;
         vectors++;
         if (idx < 96 || valid_seen || mv_b !== 1'b1 || err_b !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_frame%0d beats=%0d early_valid=%b valid=%b err=%b required 96/0/1/0", f, idx, valid_seen, mv_b, err_b);
         end
         bad_a = 0; br = 0; bc = 0;
         for (int k = 0; k < 48; k++)
            if (!bad_a && a_b[k/6][k%6] !== frb[k]) begin bad_a = 1; br = k/6; bc = k%6; end
         vectors++;
         if (bad_a) begin
            miscompares++;
            $display("FAIL rand_A%0d A[%0d][%0d]=%h required=%h", f, br, bc, a_b[br][bc], frb[br*6+bc]);
         end
         bad_b = 0; br = 0; bc = 0;
         for (int k = 0; k < 48; k++)
            if (!bad_b && b_b[k/8][k%8] !== frb[48+k]) begin bad_b = 1; br = k/8; bc = k%8; end
         vectors++;
         if (bad_b) begin
            miscompares++;
            $display("FAIL rand_B%0d B[%0d][%0d]=%h required=%h", f, br, bc, b_b[br][bc], frb[48+br*8+bc]);
         end
         hold = $urandom_range(0, 4);
         for (int h = 0; h < hold; h++) begin
            @(negedge clk); sv_b = 1'b1; sd_b = 8'($urandom);
            @(posedge clk); #1;
            vectors++;
            if (mv_b !== 1'b1 || sr_b !== 1'b0 || a_b[0][0] !== frb[0] || b_b[5][7] !== frb[95]) begin
               miscompares++;
               $display("FAIL rand_hold%0d valid=%b ready=%b required valid=1 ready=0 data held", f, mv_b, sr_b);
            end
         end
         @(negedge clk); sv_b = 1'b0; mr_b = 1'b1;
         @(posedge clk); #1; mr_b = 1'b0;
         vectors++;
         if (mv_b !== 1'b0 || sr_b !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_handshake%0d valid=%b ready=%b required valid=0 ready=1", f, mv_b, sr_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_hold();
      test_early_last();
      test_missing_last();
      test_negative();
      test_reset_mid();
      test_random_big();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
